// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and a memory-port request bundle.
// The request bundle is sized for the widest supported port; users zero-extend into it
// and slice back out to their own parameterised widths.
package dmem_arb_pkg;

   localparam int unsigned ARB_ADDR_MAX_W = 32;
   localparam int unsigned ARB_DATA_MAX_W = 64;

   typedef enum logic [0:0] {
      ST_NORM,
      ST_FORCE
   } arb_state_e;

   typedef struct packed {
      logic                      rd;
      logic                      wr;
      logic [ARB_ADDR_MAX_W-1:0] addr;
      logic [ARB_DATA_MAX_W-1:0] wdata;
      logic [2:0]                func3;
   } mem_req_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module arb_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         inc_i,
   input  logic         clr_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear, else increment while below the ceiling.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < max_i)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the MEM stage (fixed priority) and a DMA/debug requester.
// A blocked DMA request is force-granted for one stalled CPU cycle after STARVE_MAX blocked
// cycles. Optional macro DMEM_ARB_STATS_EN adds saturating blocked/forced statistics outputs.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned STARVE_MAX = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cpu_rd_i,
   input  logic                  cpu_wr_i,
   input  logic [DM_ADDRESS-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0]     cpu_wdata_i,
   input  logic [2:0]            cpu_func3_i,
   output logic [DATA_W-1:0]     cpu_rdata_o,
   output logic                  cpu_stall_o,
   input  logic                  dma_req_i,
   input  logic                  dma_we_i,
   input  logic [DM_ADDRESS-1:0] dma_addr_i,
   input  logic [DATA_W-1:0]     dma_wdata_i,
   input  logic [2:0]            dma_func3_i,
   output logic                  dma_gnt_o,
   output logic                  dma_rvalid_o,
   output logic [DATA_W-1:0]     dma_rdata_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic [DM_ADDRESS-1:0] mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic [2:0]            mem_func3_o,
`ifdef DMEM_ARB_STATS_EN
   output logic [CNT_W-1:0]      stat_blocked_o,
   output logic [CNT_W-1:0]      stat_forced_o,
`endif
   input  logic [DATA_W-1:0]     mem_rdata_i
);

   localparam int unsigned WAIT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

   if (STARVE_MAX < 1) begin : g_bad_starve
      $error("dmem_arbiter: STARVE_MAX must be >= 1");
   end
   if ((DM_ADDRESS > ARB_ADDR_MAX_W) || (DATA_W > ARB_DATA_MAX_W)) begin : g_bad_width
      $error("dmem_arbiter: port width exceeds mem_req_t capacity");
   end

   arb_state_e        state_q, state_d;
   logic              cpu_act;
   logic              blocked;
   logic              at_thresh;
   logic              force_hit;
   logic              gnt;
   logic [WAIT_W-1:0] wait_cnt;
   mem_req_t          cpu_req, dma_req, mem_req;
   logic              dma_rvalid_q, dma_rvalid_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              unused_req_bits;

   assign cpu_act   = cpu_rd_i | cpu_wr_i;
   assign blocked   = (state_q == ST_NORM) & dma_req_i & cpu_act;
   assign at_thresh = (wait_cnt == WAIT_W'(STARVE_MAX - 1));
   assign force_hit = blocked & at_thresh;

   // Package both requesters into common bundles for the port mux.
   always_comb begin
      cpu_req       = '0;
      cpu_req.rd    = cpu_rd_i;
      cpu_req.wr    = cpu_wr_i;
      cpu_req.addr  = ARB_ADDR_MAX_W'(cpu_addr_i);
      cpu_req.wdata = ARB_DATA_MAX_W'(cpu_wdata_i);
      cpu_req.func3 = cpu_func3_i;
      dma_req       = '0;
      dma_req.rd    = ~dma_we_i;
      dma_req.wr    = dma_we_i;
      dma_req.addr  = ARB_ADDR_MAX_W'(dma_addr_i);
      dma_req.wdata = ARB_DATA_MAX_W'(dma_wdata_i);
      dma_req.func3 = dma_func3_i;
   end

   // Ownership decode and port mux; an idle port still shows the CPU address/data.
   always_comb begin
      mem_req = cpu_req;
      gnt     = 1'b0;
      unique case (state_q)
         ST_NORM: begin
            if (!cpu_act && dma_req_i) begin
               mem_req = dma_req;
               gnt     = 1'b1;
            end
         end
         ST_FORCE: begin
            if (dma_req_i) begin
               mem_req = dma_req;
               gnt     = 1'b1;
            end else begin
               // Requester dropped its request: keep the port quiet rather than serve the CPU.
               mem_req.rd = 1'b0;
               mem_req.wr = 1'b0;
            end
         end
      endcase
      if (reset_i) begin
         gnt        = 1'b0;
         mem_req.rd = 1'b0;
         mem_req.wr = 1'b0;
      end
   end

   // FSM next state: a single forced cycle after the threshold blocked cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_NORM:  if (force_hit) state_d = ST_FORCE;
         ST_FORCE: state_d = ST_NORM;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_NORM;
      end else begin
         state_q <= state_d;
      end
   end

   // Consecutive blocked-cycle counter.
   arb_sat_counter #(
      .W (WAIT_W)
   ) u_wait_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (blocked & ~at_thresh),
      .clr_i   (gnt | ~dma_req_i | force_hit),
      .max_i   (WAIT_W'(STARVE_MAX - 1)),
      .count_o (wait_cnt)
   );

   // DMA read return: capture at the grant edge, pulse valid for one cycle.
   always_comb begin
      dma_rvalid_d = gnt & ~dma_we_i;
      dma_rdata_d  = dma_rvalid_d ? mem_rdata_i : dma_rdata_q;
   end

   // DMA read return registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         dma_rvalid_q <= 1'b0;
         dma_rdata_q  <= '0;
      end else begin
         dma_rvalid_q <= dma_rvalid_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   arb_sat_counter #(
      .W (CNT_W)
   ) u_stat_blocked (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (blocked),
      .clr_i   (1'b0),
      .max_i   ({CNT_W{1'b1}}),
      .count_o (stat_blocked_o)
   );

   arb_sat_counter #(
      .W (CNT_W)
   ) u_stat_forced (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (force_hit),
      .clr_i   (1'b0),
      .max_i   ({CNT_W{1'b1}}),
      .count_o (stat_forced_o)
   );
`endif

   // Stall comes straight from the state register so it cannot glitch.
   assign cpu_stall_o  = (state_q == ST_FORCE);
   assign dma_gnt_o    = gnt;
   assign dma_rvalid_o = dma_rvalid_q;
   assign dma_rdata_o  = dma_rdata_q;
   assign cpu_rdata_o  = mem_rdata_i;
   assign mem_rd_o     = mem_req.rd;
   assign mem_wr_o     = mem_req.wr;
   assign mem_addr_o   = mem_req.addr[DM_ADDRESS-1:0];
   assign mem_wdata_o  = mem_req.wdata[DATA_W-1:0];
   assign mem_func3_o  = mem_req.func3;

   // Upper bundle bits beyond the configured widths are always zero.
   assign unused_req_bits = ^{mem_req.addr, mem_req.wdata};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a small word memory attached.
module tb_dmem_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 9;
   localparam int SM   = 8;
   localparam int CW   = 16;
   localparam int NCYC = 3000;

   logic          clk, reset;
   logic          cpu_rd, cpu_wr, cpu_stall;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic [2:0]    cpu_func3;
   logic          dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic [2:0]    dma_func3;
   logic          mem_rd, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [2:0]    mem_func3;
`ifdef DMEM_ARB_STATS_EN
   logic [CW-1:0] stat_blocked, stat_forced;
`endif

   dmem_arbiter #(
      .DATA_W     (DW),
      .DM_ADDRESS (AW),
      .STARVE_MAX (SM),
      .CNT_W      (CW)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .cpu_rd_i       (cpu_rd),
      .cpu_wr_i       (cpu_wr),
      .cpu_addr_i     (cpu_addr),
      .cpu_wdata_i    (cpu_wdata),
      .cpu_func3_i    (cpu_func3),
      .cpu_rdata_o    (cpu_rdata),
      .cpu_stall_o    (cpu_stall),
      .dma_req_i      (dma_req),
      .dma_we_i       (dma_we),
      .dma_addr_i     (dma_addr),
      .dma_wdata_i    (dma_wdata),
      .dma_func3_i    (dma_func3),
      .dma_gnt_o      (dma_gnt),
      .dma_rvalid_o   (dma_rvalid),
      .dma_rdata_o    (dma_rdata),
      .mem_rd_o       (mem_rd),
      .mem_wr_o       (mem_wr),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_func3_o    (mem_func3),
`ifdef DMEM_ARB_STATS_EN
      .stat_blocked_o (stat_blocked),
      .stat_forced_o  (stat_forced),
`endif
      .mem_rdata_i    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached data memory (word wide, func3 ignored).
   logic [DW-1:0] env_mem [0:511];
   always @(posedge clk) if (mem_wr) env_mem[mem_addr] <= mem_wdata;
   assign mem_rdata = env_mem[mem_addr];

   typedef struct {
      int            cyc;
      logic          we;
      logic [AW-1:0] addr;
      logic [2:0]    f3;
      logic [DW-1:0] data;
   } exp_t;

   exp_t gnt_q[$], rv_q[$], cpu_q[$], stall_q[$];
   logic [DW-1:0] ref_mem [0:511];
   int total, bad, cyc;
   bit mon_en;

   // Reference state: blocked streak, pending forced cycle, pending DMA transfer.
   int streak, n_blocked, n_forced;
   bit in_force, pend;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic missing(input string name, input int c);
      total++;
      bad++;
      $display("FAIL %s: expected event at cycle %0d never seen", name, c);
   endtask

   function automatic exp_t mk(int c, logic we, logic [AW-1:0] a, logic [2:0] f, logic [DW-1:0] d);
      exp_t e;
      e.cyc = c; e.we = we; e.addr = a; e.f3 = f; e.data = d;
      return e;
   endfunction

   // Spec-level arbitration for the current cycle's inputs.
   task automatic model_step();
      bit gnt = 1'b0;
      bit nxt = 1'b0;
      if (in_force) begin
         stall_q.push_back(mk(cyc, 1'b0, '0, '0, '0));
         gnt    = pend;
         streak = 0;
      end else if (cpu_rd || cpu_wr) begin
         if (pend) begin
            n_blocked++;
            streak++;
            if (streak == SM) begin
               nxt = 1'b1;
               streak = 0;
               n_forced++;
            end
         end else begin
            streak = 0;
         end
         if (cpu_rd) cpu_q.push_back(mk(cyc, 1'b0, cpu_addr, cpu_func3, ref_mem[cpu_addr]));
         else ref_mem[cpu_addr] = cpu_wdata;
      end else begin
         gnt    = pend;
         streak = 0;
      end
      if (gnt) begin
         gnt_q.push_back(mk(cyc, dma_we, dma_addr, dma_func3, dma_wdata));
         if (!dma_we) rv_q.push_back(mk(cyc + 1, 1'b0, dma_addr, '0, ref_mem[dma_addr]));
         else ref_mem[dma_addr] = dma_wdata;
         pend = 1'b0;
      end
      in_force = nxt;
   endtask

   // Monitor: compare each DUT event against the head of its expectation queue.
   initial begin
      exp_t e;
      int   ec;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
               missing("dma_gnt", gnt_q[0].cyc); void'(gnt_q.pop_front());
            end
            while (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
               missing("dma_rvalid", rv_q[0].cyc); void'(rv_q.pop_front());
            end
            while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
               missing("cpu_read", cpu_q[0].cyc); void'(cpu_q.pop_front());
            end
            while (stall_q.size() > 0 && stall_q[0].cyc < cyc) begin
               missing("cpu_stall", stall_q[0].cyc); void'(stall_q.pop_front());
            end
            if (dma_gnt) begin
               ec = (gnt_q.size() > 0) ? gnt_q[0].cyc : -1;
               chk("gnt_cycle", cyc, ec);
               if (ec == cyc) begin
                  e = gnt_q.pop_front();
                  chk("gnt_addr", mem_addr, e.addr);
                  chk("gnt_wr", mem_wr, e.we);
                  chk("gnt_rd", mem_rd, !e.we);
                  chk("gnt_func3", mem_func3, e.f3);
                  if (e.we) chk("gnt_wdata", mem_wdata, e.data);
               end
            end
            if (dma_rvalid) begin
               ec = (rv_q.size() > 0) ? rv_q[0].cyc : -1;
               chk("rvalid_cycle", cyc, ec);
               if (ec == cyc) begin
                  e = rv_q.pop_front();
                  chk("dma_rdata", dma_rdata, e.data);
               end
            end
            if (mem_rd && !dma_gnt) begin
               ec = (cpu_q.size() > 0) ? cpu_q[0].cyc : -1;
               chk("cpu_rd_cycle", cyc, ec);
               if (ec == cyc) begin
                  e = cpu_q.pop_front();
                  chk("cpu_rd_addr", mem_addr, e.addr);
                  chk("cpu_rdata", cpu_rdata, e.data);
               end
            end
            if (cpu_stall) begin
               ec = (stall_q.size() > 0) ? stall_q[0].cyc : -1;
               chk("stall_cycle", cyc, ec);
               if (ec == cyc) void'(stall_q.pop_front());
            end
         end
      end
   end

   initial begin
      int r, busy, left;
      total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
      streak = 0; n_blocked = 0; n_forced = 0; in_force = 1'b0; pend = 1'b0;
      for (int i = 0; i < 512; i++) begin
         env_mem[i] = 32'h1000_0000 + i;
         ref_mem[i] = 32'h1000_0000 + i;
      end
      // Requests present during reset must not reach the port.
      reset = 1'b1;
      cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_func3 = '0;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = '0; dma_wdata = '0; dma_func3 = '0;
      #3;
      chk("rst_stall", cpu_stall, 0);
      chk("rst_gnt", dma_gnt, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_rvalid", dma_rvalid, 0);
      chk("rst_rdata", dma_rdata, 0);
      @(posedge clk); #1;
      reset = 1'b0; cpu_rd = 1'b0; dma_req = 1'b0;
      mon_en = 1'b1;

      // Random traffic; second half is CPU-heavy to force frequent starvation.
      for (int n = 0; n < NCYC; n++) begin
         @(posedge clk); #1;
         cyc++;
         busy = (n < NCYC / 2) ? 7 : 9;
         if (!in_force) begin
            r = $urandom_range(0, 9);
            cpu_rd    = (r < busy) && (r % 2 == 0 || r == 9);
            cpu_wr    = (r < busy) && !cpu_rd;
            cpu_addr  = AW'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            cpu_func3 = 3'($urandom_range(0, 7));
         end
         if (!pend && $urandom_range(0, 3) == 0) begin
            pend      = 1'b1;
            dma_we    = 1'($urandom_range(0, 1));
            dma_addr  = AW'($urandom_range(0, 15));
            dma_wdata = $urandom;
            dma_func3 = 3'($urandom_range(0, 7));
         end
         dma_req = pend;
         model_step();
      end

      // Drain: CPU goes idle so any pending DMA is served.
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         cyc++;
         if (!in_force) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
         dma_req = pend;
         model_step();
      end
      @(negedge clk); #1;
      mon_en = 1'b0;
      left = gnt_q.size() + rv_q.size() + cpu_q.size() + stall_q.size();
      chk("queues_empty", left, 0);
`ifdef DMEM_ARB_STATS_EN
      chk("stat_blocked", stat_blocked, n_blocked);
      chk("stat_forced", stat_forced, n_forced);
`endif

      // Starvation then reset in the forced cycle, then a fresh full starvation window.
      @(posedge clk); #1;
      cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = AW'(5);
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = AW'(7);
      for (int i = 1; i <= SM + 1; i++) begin
         @(negedge clk);
         if (i == 1) chk("blocked_cpu_rdata", cpu_rdata, ref_mem[5]);
         if (i <= SM) chk("starve_gnt_low", dma_gnt, 0);
         else begin
            chk("force_gnt", dma_gnt, 1);
            chk("force_stall", cpu_stall, 1);
         end
      end
      #1 reset = 1'b1;
      #1;
      chk("rst_force_stall", cpu_stall, 0);
      chk("rst_force_gnt", dma_gnt, 0);
      chk("rst_force_mem_rd", mem_rd, 0);
      chk("rst_force_rvalid", dma_rvalid, 0);
      @(posedge clk); #2 reset = 1'b0;
      for (int i = 1; i <= SM + 1; i++) begin
         @(negedge clk);
         if (i <= SM) chk("restart_gnt_low", dma_gnt, 0);
         else begin
            chk("restart_gnt", dma_gnt, 1);
            chk("restart_stall", cpu_stall, 1);
         end
      end
      @(posedge clk); #1;
      dma_req = 1'b0; cpu_rd = 1'b0;
      @(negedge clk);
      chk("restart_rvalid", dma_rvalid, 1);
      chk("restart_rdata", dma_rdata, ref_mem[7]);
      chk("restart_stall_drop", cpu_stall, 0);
`ifdef DMEM_ARB_STATS_EN
      chk("stat_blocked_post_rst", stat_blocked, SM);
      chk("stat_forced_post_rst", stat_forced, 1);
`endif
      @(negedge clk);
      chk("rvalid_one_pulse", dma_rvalid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
